layer7_weight_loader: RTL and testbench
=======================================

Name: layer7_weight_loader

Overview:
- Upstream feeder for the layer-7 weight local memory.
- Accepts 32-bit weight words from the system-side DMA/bus through a valid/ready handshake and splits each word into two 16-bit weights, low half first.
- Emits one weight per cycle on the memory's write interface: write_weight_signal, write_weight_data, write_weight_addr.
- Counts weights, stops after WEIGHT_NUM, then flags completion so the layer-7 controller can begin reads.

Parameters:
- WEIGHT_NUM, 400, total 16-bit weights per load (50 memory rows x 8 lanes); range 2..65535.
- ADDR_W, 16, width of write_weight_addr and the internal counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- in_valid  input  1  upstream word valid.
- in_data  input  32  upstream word; [15:0] is the earlier weight, [31:16] the later weight.
- in_ready  output  1  loader can accept in_data this cycle.
- write_weight_signal  output  1  write strobe to the weight memory, one weight per asserted cycle.
- write_weight_data  output  16  weight value being written.
- write_weight_addr  output  ADDR_W  sequential weight index, 0..WEIGHT_NUM-1.
- busy  output  1  high from start until load_done.
- load_done  output  1  level; high after the last weight is written, cleared by the next start.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; internal counter and holding register are cleared.
  - All outputs are 0.
  - A reset mid-load abandons the load; no further write strobes; load_done stays 0.
- States: IDLE, RECV, EMIT_LO, EMIT_HI, DONE.
- IDLE / DONE:
  - in_ready=0.
  - start moves to RECV, clears the counter and clears load_done.
  - Any other input is ignored.
- RECV:
  - in_ready=1.
  - On in_valid&in_ready, latch in_data into the 32-bit holding register and go to EMIT_LO.
  - Without in_valid, stay in RECV.
- EMIT_LO:
  - write_weight_signal=1, write_weight_data=hold[15:0], write_weight_addr=count; count increments.
  - If count was WEIGHT_NUM-1, go to DONE (odd WEIGHT_NUM: the high half of the final word is discarded).
  - Otherwise go to EMIT_HI.
  - in_ready=0.
- EMIT_HI:
  - write_weight_signal=1, write_weight_data=hold[31:16], write_weight_addr=count; count increments.
  - in_ready=1 only if at least one weight remains after this one (count < WEIGHT_NUM-1).
  - If the last weight was written, go to DONE.
  - Else, if a word is accepted this cycle, latch it and go to EMIT_LO (back-to-back, no bubble).
  - Otherwise go to RECV.
- Latency and throughput:
  - A word accepted at edge N produces its low-half strobe in cycle N+1 and its high-half strobe in cycle N+2.
  - Sustained rate is 2 weights per accepted word, with no idle cycle when in_valid stays high.
- Output timing: write outputs are registered-state driven (Moore); write_weight_data and write_weight_addr are 0 whenever write_weight_signal=0.
- DONE entry: load_done rises in the cycle after the final strobe; busy falls in the same cycle.
- start pulses in RECV, EMIT_LO or EMIT_HI are ignored (no restart).
- Upstream data offered while in_ready=0 is not consumed; in_data must be held by upstream until accepted.
- Counter never exceeds WEIGHT_NUM; no wrap within a load.

Optional Feature:
- Macro: LAYER7_WEIGHT_LOADER_CHECKSUM_EN.
- With the macro defined:
  - Adds output port weight_checksum (16 bits), a modulo-2^16 sum of every write_weight_data emitted with write_weight_signal=1.
  - Cleared by reset and by an accepted start; held stable in DONE.
- Without the macro, the port and accumulator do not exist and behaviour is otherwise identical.

Test Plan:
- Reset then idle: hold rst=0 with in_valid=1 and start pulsed -> all outputs 0. Release rst with no start -> in_ready stays 0, no strobes.
- Basic load, WEIGHT_NUM=4:
  - Stimulus: start, then words 0x0002_0001 and 0x0004_0003 with in_valid held high.
  - Required strobes on 4 consecutive cycles: data 1,2,3,4 at addr 0,1,2,3.
  - load_done=1 the following cycle; busy=0.
- Back-to-back throughput, WEIGHT_NUM=400, in_valid always 1:
  - Exactly 200 words accepted and 400 contiguous strobes with addr 0..399.
  - Final data equals word199[31:16]; in_ready=0 during the final EMIT_HI.
- Odd count, WEIGHT_NUM=5, three words with high half of word 3 = 0xDEAD:
  - Exactly 5 strobes; 0xDEAD is never written.
  - Third word accepted; no fourth word accepted.
- Upstream stalls and control corner cases:
  - Stimulus: in_valid toggled 1,0,0,1; start pulsed mid-load; rst asserted at strobe addr 7 of a 400-weight load.
  - Required: no duplicate or skipped addresses; the mid-load start has no effect.
  - After reset: outputs 0 immediately; a new start restarts from addr 0.
- Checksum (macro defined): load weights 0xFFFF,0x0002,0x0010,0x0001 -> weight_checksum=0x0012 in DONE. A new start clears it to 0.

Source files
------------

// File: rtl/layer7_weight_loader_if.sv
// Upstream word stream into the layer-7 weight loader: 32-bit words on a valid/ready handshake.
interface layer7_weight_loader_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/layer7_weight_loader.sv
// Splits 32-bit upstream words into 16-bit weights (low half first) and writes them to the layer-7 weight memory.
// Optional running checksum of written weights when LAYER7_WEIGHT_LOADER_CHECKSUM_EN is defined.
module layer7_weight_loader #(
    parameter int unsigned WEIGHT_NUM = 400,
    parameter int unsigned ADDR_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    layer7_weight_loader_if.slave      up,
    output logic                       write_weight_signal,
    output logic [15:0]                write_weight_data,
    output logic [ADDR_W-1:0]          write_weight_addr,
    output logic                       busy,
    output logic                       load_done
`ifdef LAYER7_WEIGHT_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]                weight_checksum
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_EMIT_LO,
        ST_EMIT_HI,
        ST_DONE
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WEIGHT_NUM - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [31:0]       hold_q,  hold_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        count_d             = count_q;
        hold_d              = hold_q;
        up.in_ready         = 1'b0;
        write_weight_signal = 1'b0;
        write_weight_data   = '0;
        write_weight_addr   = '0;
        busy                = 1'b0;
        load_done           = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                load_done = (state_q == ST_DONE);
                if (start) begin
                    state_d = ST_RECV;
                    count_d = '0;
                end
            end
            ST_RECV: begin
                busy        = 1'b1;
                up.in_ready = 1'b1;
                if (up.in_valid) begin
                    hold_d  = up.in_data;
                    state_d = ST_EMIT_LO;
                end
            end
            ST_EMIT_LO: begin
                busy                = 1'b1;
                write_weight_signal = 1'b1;
                write_weight_data   = hold_q[15:0];
                write_weight_addr   = count_q;
                count_d             = count_q + 1'b1;
                // Odd WEIGHT_NUM ends here and drops the final high half.
                state_d             = (count_q == LAST_IDX) ? ST_DONE : ST_EMIT_HI;
            end
            ST_EMIT_HI: begin
                busy                = 1'b1;
                write_weight_signal = 1'b1;
                write_weight_data   = hold_q[31:16];
                write_weight_addr   = count_q;
                count_d             = count_q + 1'b1;
                // Accepting the next word here keeps strobes gap-free.
                up.in_ready         = (count_q < LAST_IDX);
                if (count_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else if (up.in_valid) begin
                    hold_d  = up.in_data;
                    state_d = ST_EMIT_LO;
                end else begin
                    state_d = ST_RECV;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef LAYER7_WEIGHT_LOADER_CHECKSUM_EN
    logic        start_ok;
    logic [15:0] csum_q, csum_d;

    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        csum_d = csum_q;
        if (start_ok) begin
            csum_d = '0;
        end else if (write_weight_signal) begin
            csum_d = csum_q + write_weight_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign weight_checksum = csum_q;
`endif

endmodule

// File: tb/tb_layer7_weight_loader.sv
// Scoreboard bench for layer7_weight_loader with three instances (WEIGHT_NUM = 4, 5, 400).
module tb_layer7_weight_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4, rst5, rst400;
    logic st4, st5, st400;
    logic ws4, ws5, ws400;
    logic [15:0] wd4, wd5, wd400;
    logic [15:0] wa4, wa5, wa400;
    logic b4, b5, b400;
    logic d4, d5, d400;
`ifdef LAYER7_WEIGHT_LOADER_CHECKSUM_EN
    logic [15:0] cs4, cs5, cs400;
`endif

    layer7_weight_loader_if if4 ();
    layer7_weight_loader_if if5 ();
    layer7_weight_loader_if if400 ();

    layer7_weight_loader #(.WEIGHT_NUM(4), .ADDR_W(16)) dut4 (
        .clk(clk), .rst(rst4), .start(st4), .up(if4),
        .write_weight_signal(ws4), .write_weight_data(wd4), .write_weight_addr(wa4),
        .busy(b4), .load_done(d4)
`ifdef LAYER7_WEIGHT_LOADER_CHECKSUM_EN
        , .weight_checksum(cs4)
`endif
    );

    layer7_weight_loader #(.WEIGHT_NUM(5), .ADDR_W(16)) dut5 (
        .clk(clk), .rst(rst5), .start(st5), .up(if5),
        .write_weight_signal(ws5), .write_weight_data(wd5), .write_weight_addr(wa5),
        .busy(b5), .load_done(d5)
`ifdef LAYER7_WEIGHT_LOADER_CHECKSUM_EN
        , .weight_checksum(cs5)
`endif
    );

    layer7_weight_loader #(.WEIGHT_NUM(400), .ADDR_W(16)) dut400 (
        .clk(clk), .rst(rst400), .start(st400), .up(if400),
        .write_weight_signal(ws400), .write_weight_data(wd400), .write_weight_addr(wa400),
        .busy(b400), .load_done(d400)
`ifdef LAYER7_WEIGHT_LOADER_CHECKSUM_EN
        , .weight_checksum(cs400)
`endif
    );

    int ncomp = 0;
    int nfail = 0;
    int cyc   = 0;
    logic [31:0] q4[$], q5[$], q400[$];
    int acc[3], nstr[3], first_cyc[3], last_cyc[3], exp_addr[3];
    logic [31:0] mon_e;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int f_wn(input int k);
        case (k) 0: return 4; 1: return 5; default: return 400; endcase
    endfunction
    function automatic logic f_sig(input int k);
        case (k) 0: return ws4; 1: return ws5; default: return ws400; endcase
    endfunction
    function automatic logic [15:0] f_data(input int k);
        case (k) 0: return wd4; 1: return wd5; default: return wd400; endcase
    endfunction
    function automatic logic [15:0] f_addr(input int k);
        case (k) 0: return wa4; 1: return wa5; default: return wa400; endcase
    endfunction
    function automatic logic f_rdy(input int k);
        case (k) 0: return if4.in_ready; 1: return if5.in_ready; default: return if400.in_ready; endcase
    endfunction
    function automatic logic f_vld(input int k);
        case (k) 0: return if4.in_valid; 1: return if5.in_valid; default: return if400.in_valid; endcase
    endfunction
    function automatic logic f_busy(input int k);
        case (k) 0: return b4; 1: return b5; default: return b400; endcase
    endfunction
    function automatic logic f_done(input int k);
        case (k) 0: return d4; 1: return d5; default: return d400; endcase
    endfunction
    function automatic int qsize(input int k);
        case (k) 0: return q4.size(); 1: return q5.size(); default: return q400.size(); endcase
    endfunction

    task automatic qpush(input int k, input logic [31:0] e);
        case (k) 0: q4.push_back(e); 1: q5.push_back(e); default: q400.push_back(e); endcase
    endtask
    task automatic qpop(input int k, output logic [31:0] e);
        case (k) 0: e = q4.pop_front(); 1: e = q5.pop_front(); default: e = q400.pop_front(); endcase
    endtask
    task automatic qclear(input int k);
        case (k) 0: q4.delete(); 1: q5.delete(); default: q400.delete(); endcase
    endtask
    task automatic drive(input int k, input logic v, input logic [31:0] d);
        case (k)
            0: begin if4.in_valid = v; if4.in_data = d; end
            1: begin if5.in_valid = v; if5.in_data = d; end
            default: begin if400.in_valid = v; if400.in_data = d; end
        endcase
    endtask
    task automatic set_start(input int k, input logic v);
        case (k) 0: st4 = v; 1: st5 = v; default: st400 = v; endcase
    endtask
    task automatic set_rst(input int k, input logic v);
        case (k) 0: rst4 = v; 1: rst5 = v; default: rst400 = v; endcase
    endtask

    function automatic logic [63:0] f_outs(input int k);
        return 64'({f_sig(k), f_rdy(k), f_busy(k), f_done(k), f_addr(k), f_data(k)});
    endfunction

    // Monitor: every strobe must match the head of the expected queue; idle cycles must show zeros.
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (f_sig(k)) begin
                nstr[k]++;
                if (first_cyc[k] < 0) first_cyc[k] = cyc;
                last_cyc[k] = cyc;
                if (qsize(k) == 0) begin
                    chk($sformatf("unexpected_strobe_W%0d", f_wn(k)), 64'(qsize(k)), 64'd1);
                end else begin
                    qpop(k, mon_e);
                    chk($sformatf("strobe_W%0d", f_wn(k)), 64'({f_addr(k), f_data(k)}), 64'(mon_e));
                end
            end else begin
                chk($sformatf("idle_zero_W%0d", f_wn(k)), 64'({f_addr(k), f_data(k)}), 64'd0);
            end
            if (f_vld(k) && f_rdy(k)) acc[k]++;
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic push_exp(input int k, input logic [31:0] w);
        if (exp_addr[k] < f_wn(k)) begin
            qpush(k, {16'(exp_addr[k]), w[15:0]});
            exp_addr[k]++;
        end
        if (exp_addr[k] < f_wn(k)) begin
            qpush(k, {16'(exp_addr[k]), w[31:16]});
            exp_addr[k]++;
        end
    endtask

    task automatic start_load(input int k);
        set_start(k, 1'b1);
        @(posedge clk);
        #1;
        set_start(k, 1'b0);
        exp_addr[k] = 0; acc[k] = 0; nstr[k] = 0; first_cyc[k] = -1; last_cyc[k] = -1;
        qclear(k);
        chk($sformatf("start_busy_W%0d", f_wn(k)), 64'(f_busy(k)), 64'd1);
        chk($sformatf("start_done_clr_W%0d", f_wn(k)), 64'(f_done(k)), 64'd0);
    endtask

    task automatic pulse_start(input int k);
        set_start(k, 1'b1);
        @(posedge clk);
        #1;
        set_start(k, 1'b0);
    endtask

    task automatic send_word(input int k, input logic [31:0] w, input bit keep);
        bit got;
        got = 1'b0;
        drive(k, 1'b1, w);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (f_rdy(k)) got = 1'b1;
        end
        chk($sformatf("accept_timeout_W%0d", f_wn(k)), 64'(got), 64'd1);
        if (got) begin
            push_exp(k, w);
            @(posedge clk);
            #1;
        end
        if (!keep) drive(k, 1'b0, w);
    endtask

    task automatic wait_done(input int k);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            #1;
            if (f_done(k)) found = 1'b1;
        end
        chk($sformatf("done_timeout_W%0d", f_wn(k)), 64'(found), 64'd1);
        if (found) begin
            chk($sformatf("done_latency_W%0d", f_wn(k)), 64'(cyc), 64'(last_cyc[k] + 1));
            chk($sformatf("done_busy_low_W%0d", f_wn(k)), 64'(f_busy(k)), 64'd0);
            chk($sformatf("queue_drained_W%0d", f_wn(k)), 64'(qsize(k)), 64'd0);
            chk($sformatf("strobe_count_W%0d", f_wn(k)), 64'(nstr[k]), 64'(f_wn(k)));
            chk($sformatf("strobe_span_W%0d", f_wn(k)), 64'(last_cyc[k] - first_cyc[k] + 1), 64'(f_wn(k)));
        end
    endtask

    initial begin
        bit found;
        for (int k = 0; k < 3; k++) begin
            acc[k] = 0; nstr[k] = 0; first_cyc[k] = -1; last_cyc[k] = -1; exp_addr[k] = 0;
            set_rst(k, 1'b0);
            set_start(k, 1'b1);
            drive(k, 1'b1, 32'hFFFF_FFFF);
        end

        // Reset held with valid and start active: everything stays quiet.
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_outputs_W%0d", f_wn(k)), f_outs(k), 64'd0);
            set_start(k, 1'b0);
            set_rst(k, 1'b1);
        end
        repeat (4) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("idle_after_reset_W%0d", f_wn(k)), f_outs(k), 64'd0);
            drive(k, 1'b0, 32'h0);
        end

        // Basic 4-weight load.
        start_load(0);
        send_word(0, 32'h0002_0001, 1'b1);
        send_word(0, 32'h0004_0003, 1'b0);
        wait_done(0);
        chk("accepted_W4", 64'(acc[0]), 64'd2);

        // Odd count: high half of the third word must never be written, fourth word never taken.
        start_load(1);
        send_word(1, 32'h0002_0001, 1'b1);
        send_word(1, 32'h0004_0003, 1'b1);
        send_word(1, 32'hDEAD_0005, 1'b1);
        drive(1, 1'b1, 32'h1111_2222);
        wait_done(1);
        repeat (5) @(negedge clk);
        #1;
        chk("accepted_W5", 64'(acc[1]), 64'd3);
        chk("strobes_after_done_W5", 64'(nstr[1]), 64'd5);
        chk("done_held_W5", 64'(f_done(1)), 64'd1);
        drive(1, 1'b0, 32'h0);

        // Stalls, ignored mid-load starts, then reset at address 7.
        start_load(2);
        send_word(2, 32'h0101_0100, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        pulse_start(2);
        chk("ignored_start_recv_busy", 64'(f_busy(2)), 64'd1);
        send_word(2, 32'h0303_0302, 1'b1);
        send_word(2, 32'h0505_0504, 1'b0);
        pulse_start(2);
        send_word(2, 32'h0707_0706, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #1;
            if (ws400 && (wa400 == 16'd7)) found = 1'b1;
        end
        chk("reach_addr7", 64'(found), 64'd1);
        chk("strobes_before_reset", 64'(nstr[2]), 64'd8);
        chk("queue_before_reset", 64'(qsize(2)), 64'd0);
        set_rst(2, 1'b0);
        #1;
        chk("async_reset_outputs", f_outs(2), 64'd0);
        @(negedge clk);
        #1;
        set_rst(2, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        chk("after_reset_idle", f_outs(2), 64'd0);

        // Restart from address 0 and stream 200 words back to back.
        start_load(2);
        for (int i = 0; i < 200; i++) begin
            send_word(2, {16'h8000 | 16'(2 * i + 1), 16'(2 * i) ^ 16'h3C00}, 1'b1);
        end
        drive(2, 1'b1, 32'hBAD0_BAD0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("final_hi_addr", 64'({ws400, wa400}), 64'({1'b1, 16'd399}));
        chk("final_hi_ready", 64'(if400.in_ready), 64'd0);
        wait_done(2);
        chk("accepted_W400", 64'(acc[2]), 64'd200);
        drive(2, 1'b0, 32'h0);

`ifdef LAYER7_WEIGHT_LOADER_CHECKSUM_EN
        start_load(0);
        chk("csum_cleared_on_start", 64'(cs4), 64'd0);
        send_word(0, 32'h0002_FFFF, 1'b1);
        send_word(0, 32'h0001_0010, 1'b0);
        wait_done(0);
        chk("csum_done", 64'(cs4), 64'h0012);
        repeat (3) @(negedge clk);
        #1;
        chk("csum_held", 64'(cs4), 64'h0012);
        start_load(0);
        chk("csum_restart", 64'(cs4), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
